gps_round_sequencer: RTL

//  Sequences the GPS mock-TSS core through programmed code-generation rounds: per round, pulses the DUT reset,

---
 rtl/gps_pkg.sv | 20 ++
 rtl/gps_result_fifo.sv | 42 ++++
 rtl/gps_round_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gps_pkg.sv
// gps_pkg: shared state encoding, result record and SV stepping rule for the GPS round sequencer
package gps_pkg;
  localparam int GPS_SV_W   = 6;
  localparam int GPS_CA_W   = 13;
  localparam int GPS_CODE_W = 128;
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RST_DUT, S_WAIT_SPACE, S_START, S_WAIT_VALID, S_CAPTURE, S_NEXT
  } gps_seq_state_t;
  typedef struct packed {
    logic [GPS_SV_W-1:0]   sv;
    logic [GPS_CA_W-1:0]   ca;
    logic [GPS_CODE_W-1:0] p;
    logic [GPS_CODE_W-1:0] l;
  } gps_result_t;
  // an inverted range pins the sweep to first; reaching (or passing) last wraps back to first
  function automatic logic [GPS_SV_W-1:0] gps_next_sv(input logic [GPS_SV_W-1:0] sv, first, last,
                                                       input logic sweep);
    return !sweep ? sv : (first > last || sv >= last) ? first : sv + GPS_SV_W'(1);
  endfunction
endpackage

// File: rtl/gps_result_fifo.sv
// gps_result_fifo: result queue, push side from the sequencer, valid/ready pop side to software
// Ports: clk/rst_n, push/din/full write side, valid/ready/dout pop side, count occupancy.
module gps_result_fifo
  import gps_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  gps_result_t              din,
  output logic                     full,
  output logic                     valid,
  input  logic                     ready,
  output gps_result_t              dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  gps_result_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop, wr;
  assign pop   = valid && ready;
  // a pop in the same cycle frees the slot, so a full queue still accepts
  assign wr    = push && (!full || pop);
  assign valid = count != '0;
  assign full  = count == CW'(DEPTH);
  // empty head reads as zero so outputs are clean after reset
  assign dout  = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(pop);
    end
endmodule

// File: rtl/gps_round_sequencer.sv
// gps_round_sequencer: runs programmed code-generation rounds on the GPS mock-TSS core and queues results
// Ports: cfg_* run configuration, key_complete LLKI gate, gps_* to/from the core,
//        res_*/fifo_count result queue pop side, busy/done/err_* status.
module gps_round_sequencer
  import gps_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic                          cfg_abort,
  input  logic [7:0]                    cfg_rounds,
  input  logic                          cfg_sweep,
  input  logic [GPS_SV_W-1:0]           cfg_sv_first,
  input  logic [GPS_SV_W-1:0]           cfg_sv_last,
  input  logic [TIMEOUT_W-1:0]          cfg_timeout,
  input  logic                          key_complete,
  output logic                          gps_rst_dut,
  output logic [GPS_SV_W-1:0]           gps_sv_num,
  output logic                          gps_start_round,
  input  logic                          gps_l_code_valid,
  input  logic [GPS_CA_W-1:0]           gps_ca_code,
  input  logic [GPS_CODE_W-1:0]         gps_p_code,
  input  logic [GPS_CODE_W-1:0]         gps_l_code,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [GPS_SV_W-1:0]           res_sv,
  output logic [GPS_CA_W-1:0]           res_ca,
  output logic [GPS_CODE_W-1:0]         res_p,
  output logic [GPS_CODE_W-1:0]         res_l,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic                          err_nokey
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  gps_seq_state_t state;
  logic [7:0] rounds_q;
  logic [GPS_SV_W-1:0] sv_q, first_q;
  logic [RW-1:0] rcnt;
  logic [TIMEOUT_W-1:0] tcnt, tcnt_inc;
  logic fifo_full, space;
  gps_result_t head;
  // tcnt counts edges since the start pulse; tcnt_inc is the value after the coming edge
  assign tcnt_inc   = tcnt + TIMEOUT_W'(1);
  assign space      = !fifo_full || (res_valid && res_ready);
  assign gps_sv_num = sv_q;
  assign busy       = state != S_IDLE;
  assign res_sv     = head.sv;
  assign res_ca     = head.ca;
  assign res_p      = head.p;
  assign res_l      = head.l;
  gps_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .push  (state == S_CAPTURE),
    .din   ({sv_q, gps_ca_code, gps_p_code, gps_l_code}),
    .full  (fifo_full),
    .valid (res_valid),
    .ready (res_ready),
    .dout  (head),
    .count (fifo_count)
  );
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state           <= S_IDLE;
      rounds_q        <= '0;
      sv_q            <= '0;
      first_q         <= '0;
      rcnt            <= '0;
      tcnt            <= '0;
      gps_rst_dut     <= 1'b0;
      gps_start_round <= 1'b0;
      done            <= 1'b0;
      err_timeout     <= 1'b0;
      err_nokey       <= 1'b0;
    end else begin
      gps_rst_dut     <= 1'b0;
      gps_start_round <= 1'b0;
      done            <= 1'b0;
      if (state != S_IDLE && cfg_abort) begin
        state <= S_IDLE;
        sv_q  <= '0;
      end else case (state)
        S_IDLE: if (cfg_start && !cfg_abort) begin
          err_timeout <= 1'b0;
          err_nokey   <= 1'b0;
          rounds_q    <= cfg_rounds;
          sv_q        <= cfg_sv_first;
          first_q     <= cfg_sv_first;
          done        <= cfg_rounds == '0;
          state       <= cfg_rounds == '0 ? S_IDLE : S_CHECK;
        end
        S_CHECK: begin
          err_nokey   <= !key_complete;
          gps_rst_dut <= key_complete;
          rcnt        <= '0;
          state       <= key_complete ? S_RST_DUT : S_IDLE;
        end
        S_RST_DUT: begin
          gps_rst_dut <= rcnt != RST_LAST;
          rcnt        <= rcnt + RW'(1);
          state       <= rcnt == RST_LAST ? S_WAIT_SPACE : S_RST_DUT;
        end
        S_WAIT_SPACE: if (space) begin
          gps_start_round <= 1'b1;
          tcnt            <= '0;
          state           <= S_START;
        end
        S_START: begin
          tcnt  <= tcnt_inc;
          state <= S_WAIT_VALID;
        end
        S_WAIT_VALID:
          if (gps_l_code_valid) state <= S_CAPTURE;
          else if (cfg_timeout != '0 && tcnt_inc >= cfg_timeout) begin
            err_timeout <= 1'b1;
            gps_rst_dut <= 1'b1;
            state       <= S_IDLE;
          end else tcnt <= tcnt_inc;
        S_CAPTURE: state <= S_NEXT;
        S_NEXT: begin
          rounds_q <= rounds_q - 8'd1;
          if (rounds_q == 8'd1) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            sv_q        <= gps_next_sv(sv_q, first_q, cfg_sv_last, cfg_sweep);
            gps_rst_dut <= 1'b1;
            rcnt        <= '0;
            state       <= S_RST_DUT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule
